// File: rtl/led_pkg.sv
// Shared types and constants for the LED pattern sequencer.
// Modes cycle ROTATE -> BOUNCE -> COUNT -> BLINK -> ROTATE on each button press.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_ROTATE = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_COUNT  = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_t;

    localparam logic [3:0] SEED_ROTATE = 4'b0101;
    localparam logic [3:0] SEED_BOUNCE = 4'b0001;
    localparam logic [3:0] SEED_COUNT  = 4'b0000;
    localparam logic [3:0] SEED_BLINK  = 4'b0000;

    localparam int DEFAULT_DIV_W = 24;

    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_ROTATE: return MODE_BOUNCE;
            MODE_BOUNCE: return MODE_COUNT;
            MODE_COUNT:  return MODE_BLINK;
            default:     return MODE_ROTATE;
        endcase
    endfunction

    function automatic logic [3:0] mode_seed(input mode_t m);
        case (m)
            MODE_ROTATE: return SEED_ROTATE;
            MODE_BOUNCE: return SEED_BOUNCE;
            MODE_COUNT:  return SEED_COUNT;
            default:     return SEED_BLINK;
        endcase
    endfunction

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Board-facing signal bundle of the LED sequencer: button and speed in, LEDs and status out.
// The sequencer connects through the slave modport; the board or bench drives the master side.
interface led_pattern_sequencer_if;
    logic       btn;
    logic [1:0] spd;
    logic       D1;
    logic       D2;
    logic       D3;
    logic       D4;
    logic       D5;
    logic [1:0] mode;
    logic       step;

    modport master (
        output btn, spd,
        input  D1, D2, D3, D4, D5, mode, step
    );

    modport slave (
        input  btn, spd,
        output D1, D2, D3, D4, D5, mode, step
    );
endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability counter, and a
// one-cycle press pulse on each accepted 0->1 transition of the debounced level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a  <= 1'b0;
            sync_b  <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_a  <= btn_raw;
            sync_b  <= sync_a;
            level_d <= level;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_b;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = level & ~level_d;

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED controller top: step prescaler scaled by spd, four-mode pattern register on D1-D4,
// heartbeat on D5, and button-driven mode cycling where a press always overrides a step.
module led_pattern_sequencer
    import led_pkg::*;
#(
    parameter int TICK_DIV        = 12000000,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int DIV_W           = DEFAULT_DIV_W
) (
    input  logic                  clk,
    input  logic                  rst,
    led_pattern_sequencer_if.slave bus
);

    localparam logic [DIV_W-1:0] TICK_DIV_V = DIV_W'(TICK_DIV);

    mode_t            mode;
    logic [3:0]       pattern;
    logic [DIV_W-1:0] divider;
    logic             dir_up;
    logic             heartbeat;
    logic             step_q;

    logic             level;
    logic             press;

    logic [DIV_W-1:0] period_shift;
    logic [DIV_W-1:0] last_count;
    logic             at_end;
    logic [3:0]       next_pattern;
    logic             next_dir_up;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (bus.btn),
        .level   (level),
        .press   (press)
    );

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        period_shift = TICK_DIV_V >> bus.spd;
        last_count   = (period_shift == '0) ? '0 : period_shift - 1'b1;
        // >= rather than == so a raised speed mid-count steps on the very next cycle.
        at_end       = (divider >= last_count);

        next_pattern = pattern;
        next_dir_up  = dir_up;
        case (mode)
            MODE_ROTATE: next_pattern = {pattern[2:0], pattern[3]};
            MODE_BOUNCE: begin
                next_pattern = dir_up ? (pattern << 1) : (pattern >> 1);
                if (next_pattern == 4'b1000) begin
                    next_dir_up = 1'b0;
                end else if (next_pattern == 4'b0001) begin
                    next_dir_up = 1'b1;
                end
            end
            MODE_COUNT:  next_pattern = pattern + 4'd1;
            default:     next_pattern = ~pattern;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode      <= MODE_ROTATE;
            pattern   <= SEED_ROTATE;
            divider   <= '0;
            dir_up    <= 1'b1;
            heartbeat <= 1'b0;
            step_q    <= 1'b0;
        end else if (press) begin
            mode    <= next_mode(mode);
            pattern <= mode_seed(next_mode(mode));
            divider <= '0;
            dir_up  <= 1'b1;
            step_q  <= 1'b0;
        end else if (at_end) begin
            pattern   <= next_pattern;
            dir_up    <= next_dir_up;
            divider   <= '0;
            heartbeat <= ~heartbeat;
            step_q    <= 1'b1;
        end else begin
            divider <= divider + 1'b1;
            step_q  <= 1'b0;
        end
    end

    a_press_on_high_level : assert property (@(posedge clk) disable iff (rst) press |-> level);

    assign bus.D1   = pattern[0];
    assign bus.D2   = pattern[1];
    assign bus.D3   = pattern[2];
    assign bus.D4   = pattern[3];
    assign bus.D5   = heartbeat;
    assign bus.mode = mode;
    assign bus.step = step_q;

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
Top-level LED controller for the 12 MHz stick board. It owns the step prescaler and a 4-bit pattern register driving D1–D4. A debounced push-button cycles through four pattern modes, and a 2-bit speed input scales the step rate. D5 is a heartbeat that toggles on every step.

Parameters:
TICK_DIV, 12000000, clk cycles per pattern step at spd=0 (1 s at 12 MHz)
DEBOUNCE_CYCLES, 120000, consecutive stable synced-button cycles required to accept a new level (10 ms)
DIV_W, 24, prescaler counter width; must hold TICK_DIV-1

Ports:
clk  in  1  system clock, 12 MHz
rst  in  1  synchronous reset, active-high
btn  in  1  raw asynchronous push-button, active-high
spd  in  2  speed select; step period = max(1, TICK_DIV >> spd)
D1   out 1  pattern[0]
D2   out 1  pattern[1]
D3   out 1  pattern[2]
D4   out 1  pattern[3]
D5   out 1  heartbeat; toggles on every step
mode out 2  current mode: 0=ROTATE, 1=BOUNCE, 2=COUNT, 3=BLINK
step out 1  one-cycle pulse in the cycle the pattern advances

Behaviour:
- Reset values when rst=1 at a clk edge:
  - mode=ROTATE, pattern=4'b0101, divider=0, bounce dir=up, D5=0, step=0.
  - Synchronizer and debounce state cleared; debounced level=0.
- All state is updated only on posedge clk. Outputs are registered, except that D1–D4 are direct wires of the pattern register.
- Prescaler:
  - period = TICK_DIV >> spd; if that evaluates to 0, use 1. spd is sampled every cycle.
  - When divider >= period-1, the next cycle sets divider to 0, pulses step=1 and advances the pattern. Otherwise divider increments.
  - The >= compare guarantees a step on the next cycle when the speed is raised mid-count.
- Pattern advance per mode:
  - ROTATE: p <= {p[2:0], p[3]} (0101 -> 1010 -> 0101).
  - BOUNCE: one-hot. While dir=up, shift left; while down, shift right. dir flips to down when p becomes 1000 and to up when p becomes 0001, giving 0001,0010,0100,1000,0100,0010,0001,...
  - COUNT: p <= p+1, mod 16 (1111 -> 0000).
  - BLINK: p <= ~p (0000 <-> 1111).
- Button path:
  - Two-flop synchronizer on btn.
  - A debounce counter resets whenever the synced level equals the debounced level; otherwise it increments.
  - On reaching DEBOUNCE_CYCLES-1, the debounced level takes the synced level and the counter clears.
  - A press is a 0->1 transition of the debounced level, yielding a one-cycle pulse.
- Press handling, on the cycle after the press pulse:
  - mode <= mode+1, wrapping from BLINK to ROTATE.
  - Pattern loads the new mode's seed: ROTATE 0101, BOUNCE 0001 with dir=up, COUNT 0000, BLINK 0000.
  - divider <= 0 and step=0.
- Simultaneous press and step: the press wins. The step is dropped, D5 does not toggle, and the divider clears.
- Release (1->0) has no effect.
- Holding the button produces exactly one advance.
- Glitches shorter than DEBOUNCE_CYCLES are ignored.
- rst asserted mid-count or mid-debounce: everything returns to reset values on that edge. No pending press survives.

Decomposition:
- Package led_pkg holds:
  - mode enum: MODE_ROTATE=0, MODE_BOUNCE=1, MODE_COUNT=2, MODE_BLINK=3;
  - seed constants: SEED_ROTATE=4'b0101, SEED_BOUNCE=4'b0001, SEED_COUNT=4'b0000, SEED_BLINK=4'b0000;
  - DIV_W default.
- One sub-module, btn_debounce (params DEBOUNCE_CYCLES; ports clk, rst, btn_raw, level, press). It contains the synchronizer, debounce counter and rising-edge pulse.
- The prescaler, mode FSM and pattern logic stay in led_pattern_sequencer.

Test Plan:
All scenarios use TICK_DIV=8 and DEBOUNCE_CYCLES=4.
- Reset then run spd=0 -> step pulses every 8 cycles; D4..D1 = 0101, 1010, 0101; D5 toggles on each step; mode=0.
- spd=2 -> step every 2 cycles. Change spd from 0 to 3 while divider=6 -> step on the next cycle, then every 1 cycle.
- btn high 10 cycles -> exactly one advance to mode=1, pattern 0001. Over 12 subsequent steps, D4..D1 = 0010, 0100, 1000, 0100, 0010, 0001, ... Three-cycle btn glitch -> no mode change.
- Press to COUNT, run 17 steps -> pattern 0000..1111 then wraps to 0000 and 0001. Press to BLINK -> 0000, 1111, 0000. Press again -> mode=0, pattern 0101.
- Arrange the press pulse on the same cycle the divider reaches 7 -> no step pulse, D5 unchanged, divider 0; the next step occurs 8 cycles later.
- Assert rst for 1 cycle in BOUNCE mode mid-count with btn half-debounced -> mode=0, pattern 0101, D5=0, divider=0; no later spurious mode advance.
